// File: rtl/mac_result_buffer.sv
// mac_result_buffer: captures the final accumulation of each MAC dot product
// and queues it in a small show-ahead FIFO behind a valid/ready handshake.
module mac_result_buffer #(
    parameter int WIDTH   = 28,
    parameter int DEPTH   = 4,
    parameter int VEC_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             f_in,
    input  logic                         valid_in,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         group_done,
    output logic                         overflow,
    output logic [$clog2(VEC_LEN):0]     elem_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $clog2(VEC_LEN) + 1;

    localparam logic [EW-1:0] LAST_IDX = EW'(VEC_LEN - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic complete;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Handshake and completion decode; a pop at full frees the slot the push needs.
    always_comb begin
        complete  = valid_in && (elem_idx == LAST_IDX);
        full      = (count == FULL_CNT);
        out_valid = (count != '0);
        pop       = out_valid && out_ready;
        push      = complete && (!full || pop);
        drop      = complete && full && !pop;
        out_data  = mem[rd_ptr];
    end

    // Position within the current dot product; wraps on the final element.
    always_ff @(posedge clk) begin
        if (reset) begin
            elem_idx <= '0;
        end else if (valid_in) begin
            if (elem_idx == LAST_IDX)
                elem_idx <= '0;
            else
                elem_idx <= elem_idx + EW'(1);
        end
    end

    // Completion pulse and sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            group_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            group_done <= complete;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= f_in;
        end
    end

endmodule
